// File: rtl/register_bank_fwd.sv
// ID-stage register bank: NUM_REGS x DATA_W register file, forwarding muxes,
// immediate select on B and an ID/EX stage register. Optional macro: RF_WRITE_THROUGH_EN.
module register_bank_fwd #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 5,
   parameter int NUM_REGS   = 32,
   parameter int INS_W      = 24,
   parameter int RS_LSB     = 11,
   parameter int RT_LSB     = 6,
   parameter int IMM_W      = 8,
   parameter bit IMM_SIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INS_W-1:0]  ins,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] ans_dm,
   input  logic [DATA_W-1:0] ans_wb,
   input  logic [IMM_W-1:0]  imm,
   input  logic [ADDR_W-1:0] RW_dm,
   input  logic              wr_en,
   input  logic [1:0]        mux_sel_A,
   input  logic [1:0]        mux_sel_B,
   input  logic              imm_sel,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [ADDR_W-1:0] rs_q,
   output logic [ADDR_W-1:0] rt_q,
   output logic              out_valid
);

   localparam int              IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W:0] REG_LIMIT = NUM_REGS[ADDR_W:0];

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [ADDR_W-1:0] rs, rt;
   logic [DATA_W-1:0] rd_a, rd_b, fwd_a, fwd_b, imm_ext;
   logic              wr_ok;
   logic              unused_ins;

   // Address 0 is hardwired zero and addresses past the file do not exist.
   function automatic logic live_addr(input logic [ADDR_W-1:0] addr);
      return (addr != '0) && ({1'b0, addr} < REG_LIMIT);
   endfunction

   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                 input logic [DATA_W-1:0] rd,
                                                 input logic [DATA_W-1:0] ex,
                                                 input logic [DATA_W-1:0] dm,
                                                 input logic [DATA_W-1:0] wb);
      case (sel)
         2'b01:   return ex;
         2'b10:   return dm;
         2'b11:   return wb;
         default: return rd;
      endcase
   endfunction

   assign rs         = ins[RS_LSB +: ADDR_W];
   assign rt         = ins[RT_LSB +: ADDR_W];
   assign wr_ok      = wr_en && live_addr(RW_dm);
   assign unused_ins = ^ins;

   // NOTE: the whole file is reset so a mid-operation reset leaves no stale data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[RW_dm[IDX_W-1:0]] <= ans_dm;
      end
   end

   // NOTE: each read result gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (live_addr(rs)) rd_a = regs[rs[IDX_W-1:0]];
      if (live_addr(rt)) rd_b = regs[rt[IDX_W-1:0]];
`ifdef RF_WRITE_THROUGH_EN
      if (wr_ok && (RW_dm == rs)) rd_a = ans_dm;
      if (wr_ok && (RW_dm == rt)) rd_b = ans_dm;
`endif
   end

   if (IMM_W < DATA_W) begin : g_imm_ext
      assign imm_ext = IMM_SIGNED ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                                  : {{(DATA_W-IMM_W){1'b0}}, imm};
   end else begin : g_imm_full
      assign imm_ext = imm;
   end

   assign fwd_a = fwd_mux(mux_sel_A, rd_a, ans_ex, ans_dm, ans_wb);
   assign fwd_b = imm_sel ? imm_ext : fwd_mux(mux_sel_B, rd_b, ans_ex, ans_dm, ans_wb);

   // NOTE: state is updated with non-blocking assignments so all stage fields move together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A         <= '0;
         B         <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         A         <= '0;
         B         <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         A         <= fwd_a;
         B         <= fwd_b;
         rs_q      <= rs;
         rt_q      <= rt;
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_register_bank_fwd.sv
// Directed bench for register_bank_fwd: expected stage contents are queued when
// stimulus is driven and compared after the clock edge that should produce them.
module tb_register_bank_fwd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] ins;
   logic [7:0]  ans_ex, ans_dm, ans_wb, imm;
   logic [3:0]  imm_s;
   logic [4:0]  RW_dm;
   logic        wr_en, imm_sel, in_valid, stall, flush;
   logic [1:0]  mux_sel_A, mux_sel_B;
   logic [7:0]  A, B, A_s, B_s;
   logic [4:0]  rs_q, rt_q, rs_s, rt_s;
   logic        out_valid, valid_s;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       v;
   } stage_t;

   stage_t sb[$];

`ifdef RF_WRITE_THROUGH_EN
   localparam logic [7:0] WT_A = 8'h77;
`else
   localparam logic [7:0] WT_A = 8'h3C;
`endif

   register_bank_fwd dut (
      .clk(clk), .rst_n(rst_n), .ins(ins), .ans_ex(ans_ex), .ans_dm(ans_dm),
      .ans_wb(ans_wb), .imm(imm), .RW_dm(RW_dm), .wr_en(wr_en),
      .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .A(A), .B(B), .rs_q(rs_q), .rt_q(rt_q), .out_valid(out_valid)
   );

   // Reduced file and 4-bit signed immediate share every other input.
   register_bank_fwd #(.NUM_REGS(16), .IMM_W(4), .IMM_SIGNED(1'b1)) dut_small (
      .clk(clk), .rst_n(rst_n), .ins(ins), .ans_ex(ans_ex), .ans_dm(ans_dm),
      .ans_wb(ans_wb), .imm(imm_s), .RW_dm(RW_dm), .wr_en(wr_en),
      .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .A(A_s), .B(B_s), .rs_q(rs_s), .rt_q(rt_s), .out_valid(valid_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [4:0] rs, input logic [4:0] rt, input logic v);
      stage_t e;
      sb.push_back('{a: a, b: b, rs: rs, rt: rt, v: v});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, ".A"},  32'(A),         32'(e.a));
      check({tag, ".B"},  32'(B),         32'(e.b));
      check({tag, ".rs"}, 32'(rs_q),      32'(e.rs));
      check({tag, ".rt"}, 32'(rt_q),      32'(e.rt));
      check({tag, ".v"},  32'(out_valid), 32'(e.v));
   endtask

   initial begin
      rst_n = 1'b1;
      ins = '0; ans_ex = '0; ans_dm = '0; ans_wb = '0; imm = '0; imm_s = '0;
      RW_dm = '0; wr_en = 1'b0; mux_sel_A = 2'b00; mux_sel_B = 2'b00;
      imm_sel = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst.A", 32'(A), 0);
      check("rst.B", 32'(B), 0);
      check("rst.v", 32'(out_valid), 0);
      check("rst.small_A", 32'(A_s), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Register writes, then a plain read of both
      wr_en = 1'b1; RW_dm = 5'd9;  ans_dm = 8'h3C;
      tick("wr_r9", 8'h00, 8'h00, 5'd0, 5'd0, 1'b0);
      RW_dm = 5'd17; ans_dm = 8'hA5;
      tick("wr_r17", 8'h00, 8'h00, 5'd0, 5'd0, 1'b0);
      wr_en = 1'b0; ins = 24'h014c50; in_valid = 1'b1;
      tick("rd", 8'h3C, 8'hA5, 5'd9, 5'd17, 1'b1);
      check("small.rd_r17", 32'(B_s), 0);
      check("small.rd_r9",  32'(A_s), 32'h3C);

      // Forwarding and immediate
      ans_ex = 8'hC0; ans_dm = 8'hD0; ans_wb = 8'hE0;
      mux_sel_A = 2'b11; mux_sel_B = 2'b10;
      tick("fwd_wb_dm", 8'hE0, 8'hD0, 5'd9, 5'd17, 1'b1);
      mux_sel_A = 2'b01; imm_sel = 1'b1; imm = 8'hFF; imm_s = 4'h8;
      tick("fwd_ex_imm", 8'hC0, 8'hFF, 5'd9, 5'd17, 1'b1);
      check("small.imm_sext", 32'(B_s), 32'hF8);
      check("small.fwd_ex",   32'(A_s), 32'hC0);

      // R0 is hardwired zero
      mux_sel_A = 2'b00; mux_sel_B = 2'b00; imm_sel = 1'b0;
      ins = 24'h000000; wr_en = 1'b1; RW_dm = 5'd0; ans_dm = 8'h55;
      tick("wr_r0", 8'h00, 8'h00, 5'd0, 5'd0, 1'b1);
      wr_en = 1'b0;
      tick("rd_r0", 8'h00, 8'h00, 5'd0, 5'd0, 1'b1);

      // Same-cycle write and read of R9
      ins = 24'h014c50; wr_en = 1'b1; RW_dm = 5'd9; ans_dm = 8'h77;
      tick("write_through", WT_A, 8'hA5, 5'd9, 5'd17, 1'b1);
      wr_en = 1'b0;
      tick("rd_r9_new", 8'h77, 8'hA5, 5'd9, 5'd17, 1'b1);

      // Stall holds the stage while a write to R5 still lands
      stall = 1'b1; ins = 24'h008A40; in_valid = 1'b0;
      wr_en = 1'b1; RW_dm = 5'd5; ans_dm = 8'h5A;
      for (int i = 0; i < 3; i++) tick("stall", 8'h77, 8'hA5, 5'd9, 5'd17, 1'b1);
      stall = 1'b0; wr_en = 1'b0; ins = 24'h002800; in_valid = 1'b1;
      tick("post_stall", 8'h5A, 8'h00, 5'd5, 5'd0, 1'b1);

      // Flush beats stall
      stall = 1'b1; flush = 1'b1;
      tick("flush", 8'h00, 8'h00, 5'd0, 5'd0, 1'b0);

      // Address 20 exists only in the 32-entry file
      stall = 1'b0; flush = 1'b0; in_valid = 1'b0; ins = 24'h000000;
      wr_en = 1'b1; RW_dm = 5'd20; ans_dm = 8'h99;
      tick("wr_r20", 8'h00, 8'h00, 5'd0, 5'd0, 1'b0);
      wr_en = 1'b0; ins = 24'h004D00; in_valid = 1'b1;
      tick("rd_r20", 8'h77, 8'h99, 5'd9, 5'd20, 1'b1);
      check("small.rd_r20", 32'(B_s),  0);
      check("small.rt_q",   32'(rt_s), 32'd20);
      check("small.rd_r9b", 32'(A_s),  32'h77);

      // Asynchronous reset between clock edges
      #3 rst_n = 1'b0;
      #1;
      check("async_rst.A",  32'(A), 0);
      check("async_rst.B",  32'(B), 0);
      check("async_rst.rs", 32'(rs_q), 0);
      check("async_rst.v",  32'(out_valid), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick("post_rst_rd", 8'h00, 8'h00, 5'd9, 5'd20, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
